// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, baud arithmetic and line levels.
// Used by uart_tx and the matching receiver so both sides agree on the frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int cycles_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CYCLES-1 while enabled and wraps, flagging the last
// cycle of a bit (bit_end) and the one before it (pre_end).
module uart_bit_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_end,
  output logic pre_end
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] count;

  assign bit_end = (count == CNT_W'(CYCLES - 1));
  assign pre_end = (count == CNT_W'(CYCLES - 2));

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N data bits LSB first, optional parity, M stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects polarity).
module uart_tx
  import uart_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 1,
  parameter int BAUD_RATE = 9600,
`ifdef UART_TX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int CLK_FREQ  = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         valid,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BIT_CNT_W      = $clog2(N);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(N - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(M - 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (N < 5 || N > 9 || M < 1 || M > 2) begin : g_bad_frame
    $error("uart_tx: N must be 5..9 and M must be 1 or 2");
  end

  uart_state_t          state;
  logic [N-1:0]         shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 bit_end;
  logic                 pre_end;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = valid && ready;

  uart_bit_timer #(
    .CYCLES(CYCLES_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .enable (busy),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= LINE_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            tx        <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            shift_reg <= data_in;
            bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^data_in) ^ PARITY_ODD;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= LINE_IDLE;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx      <= LINE_IDLE;
            bit_cnt <= '0;
          end
        end
`endif
        STOP: begin
          // done is registered, so it is raised one cycle ahead of the final stop-bit clk
          if (bit_cnt == STOP_LAST && pre_end) done <= 1'b1;
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              ready   <= 1'b1;
              busy    <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clks per bit: cycle-exact frame model,
// a scoreboard-fed line decoder, reset, back-to-back and ignored-valid sequences.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_A = (1 + 8 + P + 1) * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a;
  logic       valid_a, ready_a, tx_a, busy_a, done_a;
  logic [6:0] data_b;
  logic       valid_b, ready_b, tx_b, busy_b, done_b;
`ifdef UART_TX_PARITY_EN
  logic [7:0] data_c;
  logic       valid_c, ready_c, tx_c, busy_c, done_c;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       even_par;
  } vec_t;

  always #5 clk = ~clk;

  uart_tx #(.N(8), .M(1), .BAUD_RATE(10), .CLK_FREQ(160)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx #(.N(7), .M(2), .BAUD_RATE(10), .CLK_FREQ(160)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx #(.N(8), .M(1), .BAUD_RATE(10), .PARITY_ODD(1'b1), .CLK_FREQ(160)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_c), .valid(valid_c),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {ready, busy, done, tx} of the selected instance
  function automatic logic [3:0] outs(input int sel);
    case (sel)
      0: return {ready_a, busy_a, done_a, tx_a};
      1: return {ready_b, busy_b, done_b, tx_b};
`ifdef UART_TX_PARITY_EN
      2: return {ready_c, busy_c, done_c, tx_c};
`endif
      default: return 4'bxxxx;
    endcase
  endfunction

  // Called at the negedge right after the accepting edge; returns one cycle after the frame.
  task automatic check_frame(input int sel, input logic [8:0] word, input int n, input int m,
                             input logic par, input string tag);
    int nbits = 1 + n + P + m;
    int frame = nbits * CPB;
    int bit_err[16];
    int ctl_err = 0;
    int done_err = 0;
    int b;
    logic [3:0] o;
    logic exp;
    foreach (bit_err[i]) bit_err[i] = 0;
    for (int c = 0; c < frame; c++) begin
      if (c > 0) @(negedge clk);
      o = outs(sel);
      b = c / CPB;
      if (b == 0) exp = 1'b0;
      else if (b <= n) exp = word[b-1];
      else if (P == 1 && b == n + 1) exp = par;
      else exp = 1'b1;
      if (o[0] !== exp) bit_err[b]++;
      if (o[3:2] !== 2'b01) ctl_err++;
      if (o[1] !== (c == frame - 1)) done_err++;
    end
    for (int i = 0; i < nbits; i++)
      check($sformatf("%s bit%0d tx bad cycles", tag, i), bit_err[i], 0);
    check({tag, " ready/busy bad cycles"}, ctl_err, 0);
    check({tag, " done bad cycles"}, done_err, 0);
    @(negedge clk);
    check({tag, " idle outputs after frame"}, outs(sel), 4'b1001);
  endtask

  task automatic send_a(input logic [7:0] w);
    @(negedge clk);
    valid_a = 1'b1;
    data_a  = w;
    sb.push_back(w);
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  // Line decoder for dut_a: samples mid-bit and compares against the scoreboard.
  initial begin : mon_a
    forever begin
      @(negedge clk);
      if (!reset && tx_a === 1'b0) begin : frame_blk
        logic [7:0] w;
        logic [7:0] exp;
        logic parb;
        bit framing_ok;
        bit aborted;
        int b;
        w = '0; exp = '0; parb = 1'b0; framing_ok = 1'b1; aborted = 1'b0;
        for (int c = 1; c < FRAME_A; c++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) begin
            b = c / CPB;
            if (b == 0) begin
              if (tx_a !== 1'b0) framing_ok = 1'b0;
            end else if (b <= 8) begin
              w[b-1] = tx_a;
            end else if (P == 1 && b == 9) begin
              parb = tx_a;
            end else if (tx_a !== 1'b1) begin
              framing_ok = 1'b0;
            end
          end
        end
        if (!aborted) begin
          check("decoder frame expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("decoder word", w, exp);
            check("decoder start/stop framing", framing_ok, 1'b1);
            if (P == 1) check("decoder parity", parb, ^exp);
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   stray;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h01, 1'b1};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h3C, 1'b0};
    vecs[6] = '{8'h07, 1'b1};
    vecs[7] = '{8'h6E, 1'b1};

    reset = 1'b1;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
`ifdef UART_TX_PARITY_EN
    valid_c = 1'b0; data_c = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset outputs a", outs(0), 4'b1001);
    check("reset outputs b", outs(1), 4'b1001);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table of single frames, including all-0 and all-1 words
    for (int i = 0; i < 8; i++) begin
      send_a(vecs[i].data);
      check_frame(0, {1'b0, vecs[i].data}, 8, 1, vecs[i].even_par, $sformatf("vec%0d", i));
    end

    // Reset 40 clks into a frame: outputs return to idle without a clock edge
    send_a(8'h96);
    repeat (40) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset tx", tx_a, 1'b1);
    check("async reset ready", ready_a, 1'b1);
    check("async reset busy", busy_a, 1'b0);
    check("async reset done", done_a, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_a(8'hC3);
    check_frame(0, 9'h0C3, 8, 1, 1'b0, "post-reset");

    // Back-to-back with valid held: second start bit 161 clks after the first
    @(negedge clk);
    valid_a = 1'b1;
    data_a  = 8'h00;
    sb.push_back(8'h00);
    @(negedge clk);
    data_a = 8'h33;
    check_frame(0, 9'h000, 8, 1, 1'b0, "b2b first");
    data_a = 8'hFF;
    sb.push_back(8'hFF);
    @(negedge clk);
    valid_a = 1'b0;
    check_frame(0, 9'h0FF, 8, 1, 1'b0, "b2b second");

    // valid pulsed mid-frame is ignored
    send_a(8'h5A);
    fork
      check_frame(0, 9'h05A, 8, 1, 1'b0, "ignored valid");
      begin
        repeat (50) @(negedge clk);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
      end
    join
    stray = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ready_a !== 1'b1) stray++;
    end
    check("no stray frame after ignored valid", stray, 0);

    // N=7, M=2: two stop bits, 160-clk frame without parity
    @(negedge clk);
    valid_b = 1'b1;
    data_b  = 7'h55;
    @(negedge clk);
    valid_b = 1'b0;
    check_frame(1, 9'h055, 7, 2, 1'b0, "n7m2");

`ifdef UART_TX_PARITY_EN
    // Odd parity of 8'h07 is 0
    @(negedge clk);
    valid_c = 1'b1;
    data_c  = 8'h07;
    @(negedge clk);
    valid_c = 1'b0;
    check_frame(2, 9'h007, 8, 1, 1'b0, "odd parity");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
